// File: rtl/poly_accumulator_if.sv
// Partial-product stream into the accumulator and the coefficient
// stream out of it. "slave" is the accumulator side and "master" is the
// producer/consumer side.
interface poly_accumulator_if #(
  parameter int IDX_W = 11
);
  logic             B_valid;
  logic [IDX_W-1:0] idx_B;
  logic [41:0]      B_out;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [9:0]       out_idx;
  logic [5:0]       out_coef;
  logic             out_last;
  logic             frame_done;
  logic             err;

  modport slave (
    input  B_valid, idx_B, B_out, out_ready,
    output in_ready, out_valid, out_idx, out_coef, out_last, frame_done, err
  );

  modport master (
    output B_valid, idx_B, B_out, out_ready,
    input  in_ready, out_valid, out_idx, out_coef, out_last, frame_done, err
  );
endinterface

// File: rtl/poly_accumulator.sv
// poly_accumulator: adds streamed 6-bit partial coefficients into a
// DEPTH-entry polynomial, reduced modulo x^DEPTH - 1. After WORDS input
// words the polynomial is drained one coefficient per handshake, and each
// entry is cleared as it leaves.
// Optional build macro NEGACYCLIC_EN: the reduction becomes x^DEPTH + 1,
// so wrapped fields are subtracted instead of added.
//
// state | meaning
// ACCUM | accepting input words, one per cycle, no back-pressure
// DRAIN | presenting mem[didx] on the output handshake
module poly_accumulator #(
  parameter int DEPTH = 784,
  parameter int IDX_W = 11,
  parameter int WORDS = (DEPTH / 4) * (DEPTH / 4)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  poly_accumulator_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [IDX_W:0]   DEPTH_P     = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   TWO_DEPTH_P = (IDX_W + 1)'(2 * DEPTH);
  localparam logic [AW-1:0]    LAST_IDX    = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'b00,
    DRAIN = 2'b01
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    didx_q, didx_d;
  logic [5:0]       mem_q [DEPTH];
  logic [5:0]       mem_d [DEPTH];
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [IDX_W:0]   pos;
  logic [5:0]       field;
  logic             drop;

  // A word whose top field would land beyond one wrap cannot be reduced
  // with a single subtraction, so it is rejected as a whole.
  assign drop = (({1'b0, bus.idx_B} + (IDX_W + 1)'(6)) >= TWO_DEPTH_P);

  // State, counters and the coefficient array.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      didx_q  <= '0;
      mem_q   <= '{default: '0};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      didx_q  <= didx_d;
      mem_q   <= mem_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. The seven fields are folded into mem_d one after
  // another, so fields that hit the same entry all count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    didx_d  = didx_q;
    mem_d   = mem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pos     = '0;
    field   = '0;

    case (state_q)
      ACCUM: begin
        if (bus.B_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (drop) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < 7; k++) begin
              field = bus.B_out[6*k +: 6];
              pos   = {1'b0, bus.idx_B} + (IDX_W + 1)'(k);
              if (pos >= DEPTH_P) begin
                pos = pos - DEPTH_P;
`ifdef NEGACYCLIC_EN
                mem_d[AW'(pos)] = mem_d[AW'(pos)] - field;
`else
                mem_d[AW'(pos)] = mem_d[AW'(pos)] + field;
`endif
              end else begin
                mem_d[AW'(pos)] = mem_d[AW'(pos)] + field;
              end
            end
          end
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            didx_d  = '0;
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (bus.B_valid) err_d = 1'b1;
        if (bus.out_ready) begin
          mem_d[didx_q] = '0;
          if (didx_q == LAST_IDX) begin
            didx_d  = '0;
            done_d  = 1'b1;
            state_d = ACCUM;
          end else begin
            didx_d = didx_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
        didx_d  = '0;
      end
    endcase
  end

  assign bus.in_ready   = (state_q == ACCUM);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_idx    = 10'(didx_q);
  assign bus.out_coef   = (state_q == DRAIN) ? mem_q[didx_q] : 6'd0;
  assign bus.out_last   = (state_q == DRAIN) && (didx_q == LAST_IDX);
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;

endmodule
